// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared constants and helpers for the matrix keypad scanner.
//   clog2          : ceiling log2, usable in constant expressions
//   width_of       : clog2 with a floor of 1, for counters and index buses
//   row_onehot_low : one-hot active-low row pattern for row index r
//                    (MAX_ROWS bits wide; callers cast down to their ROWS)
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int DEF_ROWS     = 4;
    localparam int DEF_COLS     = 4;
    localparam int DEF_SCAN_DIV = 60000;
    localparam int DEF_DEBOUNCE = 2;

    // Widest row bus row_onehot_low can produce.
    localparam int MAX_ROWS = 32;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int width_of(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

    function automatic logic [MAX_ROWS-1:0] row_onehot_low(input int unsigned r);
        return ~(MAX_ROWS'(1) << r);
    endfunction

endpackage

// File: rtl/keypad_debounce_cell.sv
// -----------------------------------------------------------------------------
// keypad_debounce_cell
// Debounce filter for one key: a run-length counter of samples that disagree
// with the committed state, plus the state flop and its edge pulses.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : one cycle per scan of this key's row (sample strobe)
//   sample        : raw column level for this key, active-low
//   state         : debounced level, 0 = pressed (resets to 1)
//   press_pulse   : 1 clk on a committed 1->0 transition
//   release_pulse : 1 clk on a committed 0->1 transition
// -----------------------------------------------------------------------------
module keypad_debounce_cell
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sample,
    output logic state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = clog2(DEBOUNCE + 1);

    logic [CW-1:0] cnt;

    // NOTE: state flops use non-blocking assignments so every cell, and the
    // top-level registers, see the pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            state         <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            // Pulses are single-cycle unless re-armed by a commit below.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (en) begin
                if (sample == state) begin
                    // Any agreeing sample restarts the run, which is what
                    // rejects bounces.
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE - 1)) begin
                    // This sample would bring the run to DEBOUNCE: commit.
                    cnt           <= '0;
                    state         <= sample;
                    press_pulse   <= ~sample;
                    release_pulse <= sample;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/matrix_keypad_scan.sv
// -----------------------------------------------------------------------------
// matrix_keypad_scan
// ROWS x COLS matrix keypad scanner. One row is driven low per scan slot of
// SCAN_DIV clocks; at the end of each slot the columns are sampled for that
// row and the row ring advances. Each key has its own debounce cell.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   col         : column inputs, active-low (0 = key closed on driven row)
//   row         : row drive, one-hot active-low
//   key_state   : debounced levels, bit i = 0 means key i pressed
//   key_press   : 1-clk pulse per key on a committed press
//   key_release : 1-clk pulse per key on a committed release
//   key_valid   : 1-clk pulse when at least one press is committed
//   key_code    : lowest newly pressed key index, held between key_valid
//   multi_key   : 1 while two or more keys are debounced-pressed
// Key index i = r*COLS + c. col is sampled only after a full slot of row
// settling; it should come from clean (board-filtered or synchronised) pins.
// ROWS must not exceed keypad_pkg::MAX_ROWS.
// -----------------------------------------------------------------------------
module matrix_keypad_scan
    import keypad_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [COLS-1:0]                   col,
    output logic [ROWS-1:0]                   row,
    output logic [ROWS*COLS-1:0]              key_state,
    output logic [ROWS*COLS-1:0]              key_press,
    output logic [ROWS*COLS-1:0]              key_release,
    output logic                              key_valid,
    output logic [width_of(ROWS*COLS)-1:0]    key_code,
    output logic                              multi_key
);

    localparam int NKEYS = ROWS * COLS;
    localparam int KW    = width_of(NKEYS);
    localparam int CNT_W = width_of(SCAN_DIV);
    localparam int RW    = width_of(ROWS);

    // ---------------------------------------------------------------------
    // Prescaler and row ring
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;
    logic [RW-1:0]    scan_idx;
    logic [RW-1:0]    scan_next;
    logic             tick;

    assign tick      = (cnt == CNT_W'(SCAN_DIV - 1));
    assign scan_next = (scan_idx == RW'(ROWS - 1)) ? '0 : scan_idx + RW'(1);

    // row is kept as its own register (rather than decoded from scan_idx) so
    // the pins never glitch during the index change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            scan_idx <= '0;
            row      <= ROWS'(row_onehot_low(0));
        end else if (tick) begin
            cnt      <= '0;
            scan_idx <= scan_next;
            row      <= ROWS'(row_onehot_low(32'(scan_next)));
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Per-key debounce cells
    // ---------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic row_en;
        // Sample on the last cycle of this row's slot, before the ring moves.
        assign row_en = tick && (scan_idx == RW'(r));

        for (genvar c = 0; c < COLS; c++) begin : g_col
            keypad_debounce_cell #(
                .DEBOUNCE(DEBOUNCE)
            ) u_cell (
                .clk          (clk),
                .rst_n        (rst_n),
                .en           (row_en),
                .sample       (col[c]),
                .state        (key_state[r*COLS + c]),
                .press_pulse  (key_press[r*COLS + c]),
                .release_pulse(key_release[r*COLS + c])
            );
        end
    end

    // ---------------------------------------------------------------------
    // Encoder: key_press is already registered, so key_valid and a bypassed
    // key_code line up with the press pulses in the same cycle.
    // ---------------------------------------------------------------------
    logic [KW-1:0] lowest_press;
    logic [KW-1:0] code_q;

    // NOTE: every always_comb output gets a default before any condition,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        lowest_press = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (key_press[i]) begin
                lowest_press = KW'(i);
            end
        end
    end

    assign key_valid = |key_press;
    assign key_code  = key_valid ? lowest_press : code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
        end else begin
            code_q <= key_code;
        end
    end

    // ---------------------------------------------------------------------
    // Chord detect: saturating count of pressed keys, registered.
    // ---------------------------------------------------------------------
    logic seen_one;
    logic seen_two;

    always_comb begin
        seen_one = 1'b0;
        seen_two = 1'b0;
        for (int i = 0; i < NKEYS; i++) begin
            if (!key_state[i]) begin
                if (seen_one) begin
                    seen_two = 1'b1;
                end
                seen_one = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_key <= 1'b0;
        end else begin
            multi_key <= seen_two;
        end
    end

endmodule

// File: tb/tb_matrix_keypad_scan.sv
// -----------------------------------------------------------------------------
// tb_matrix_keypad_scan
// Directed bench for matrix_keypad_scan with ROWS=4, COLS=4, SCAN_DIV=4,
// DEBOUNCE=2 (one frame = 16 clk). A behavioural keypad drives col low for
// every pressed key whose row is currently driven low.
// -----------------------------------------------------------------------------
module tb_matrix_keypad_scan;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int NKEYS    = ROWS * COLS;
    localparam int BUDGET   = 200;

    logic             clk;
    logic             rst_n;
    logic [COLS-1:0]  col;
    logic [ROWS-1:0]  row;
    logic [NKEYS-1:0] key_state;
    logic [NKEYS-1:0] key_press;
    logic [NKEYS-1:0] key_release;
    logic             key_valid;
    logic [3:0]       key_code;
    logic             multi_key;

    logic [NKEYS-1:0] pressed;

    int tests;
    int fails;

    // Pulse accumulators, cleared by the scenarios.
    logic [NKEYS-1:0] press_acc;
    logic [NKEYS-1:0] release_acc;
    int               valid_cnt;

    matrix_keypad_scan #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .col        (col),
        .row        (row),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .multi_key  (multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a closed key shorts its column to its row.
    always_comb begin
        col = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!row[r] && pressed[r*COLS + c]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        press_acc   = press_acc | key_press;
        release_acc = release_acc | key_release;
        if (key_valid) valid_cnt = valid_cnt + 1;
    end

    function automatic logic [ROWS-1:0] row_pat(input int r);
        logic [ROWS-1:0] p;
        p    = '1;
        p[r] = 1'b0;
        return p;
    endfunction

    task automatic clear_acc();
        press_acc   = '0;
        release_acc = '0;
        valid_cnt   = 0;
    endtask

    // Returns at the negedge right after row r has been sampled (the row
    // ring moves on the same edge as the sample).
    task automatic wait_row_sample(input int r);
        int n;
        n = 0;
        while (row !== row_pat(r) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        while (row === row_pat(r) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            tests++;
            fails++;
            $display("FAIL wait_row_sample(%0d): timeout after %0d cycles, row=%b", r, n, row);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if (row !== 4'b1110 || key_state !== 16'hFFFF || key_press !== 16'h0000 ||
            key_release !== 16'h0000 || key_valid !== 1'b0 || key_code !== 4'd0 ||
            multi_key !== 1'b0) begin
            fails++;
            $display("FAIL %s: row=%b key_state=%h press=%h release=%h valid=%b code=%0d multi=%b, expected 1110/FFFF/0000/0000/0/0/0",
                     tag, row, key_state, key_press, key_release, key_valid, key_code, multi_key);
        end
    endtask

    task automatic test_reset();
        logic [ROWS-1:0] exp_row;
        rst_n   = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_row = row_pat((k / SCAN_DIV) % ROWS);
            tests++;
            if (row !== exp_row) begin
                fails++;
                $display("FAIL scan_row clk%0d: row=%b expected %b", k, row, exp_row);
            end
        end
    endtask

    task automatic test_press();
        pressed[6] = 1'b1;
        clear_acc();
        wait_row_sample(1);
        tests++;
        if (key_state !== 16'hFFFF || press_acc !== 16'h0000 || valid_cnt != 0) begin
            fails++;
            $display("FAIL press_first_sample: key_state=%h press_acc=%h valid_cnt=%0d, expected FFFF/0000/0",
                     key_state, press_acc, valid_cnt);
        end
        wait_row_sample(1);
        tests++;
        if (key_state !== 16'hFFBF || key_press !== 16'h0040 || key_valid !== 1'b1 ||
            key_code !== 4'd6 || multi_key !== 1'b0) begin
            fails++;
            $display("FAIL press_commit: key_state=%h press=%h valid=%b code=%0d multi=%b, expected FFBF/0040/1/6/0",
                     key_state, key_press, key_valid, key_code, multi_key);
        end
        @(negedge clk);
        tests++;
        if (key_press !== 16'h0000 || key_valid !== 1'b0 || key_code !== 4'd6 ||
            multi_key !== 1'b0 || valid_cnt != 1) begin
            fails++;
            $display("FAIL press_pulse_width: press=%h valid=%b code=%0d multi=%b valid_cnt=%0d, expected 0000/0/6/0/1",
                     key_press, key_valid, key_code, multi_key, valid_cnt);
        end
    endtask

    task automatic test_release();
        pressed[6] = 1'b0;
        clear_acc();
        wait_row_sample(1);
        tests++;
        if (key_state !== 16'hFFBF || release_acc !== 16'h0000) begin
            fails++;
            $display("FAIL release_first_sample: key_state=%h release_acc=%h, expected FFBF/0000",
                     key_state, release_acc);
        end
        wait_row_sample(1);
        tests++;
        if (key_state !== 16'hFFFF || key_release !== 16'h0040 || key_valid !== 1'b0 ||
            key_code !== 4'd6) begin
            fails++;
            $display("FAIL release_commit: key_state=%h release=%h valid=%b code=%0d, expected FFFF/0040/0/6",
                     key_state, key_release, key_valid, key_code);
        end
        @(negedge clk);
        tests++;
        if (key_release !== 16'h0000 || valid_cnt != 0 || press_acc !== 16'h0000) begin
            fails++;
            $display("FAIL release_pulse_width: release=%h valid_cnt=%0d press_acc=%h, expected 0000/0/0000",
                     key_release, valid_cnt, press_acc);
        end
    endtask

    task automatic test_glitch();
        clear_acc();
        pressed[6] = 1'b1;
        wait_row_sample(1);
        pressed[6] = 1'b0;
        wait_row_sample(1);
        wait_row_sample(1);
        tests++;
        if (key_state !== 16'hFFFF || press_acc !== 16'h0000 || release_acc !== 16'h0000 ||
            valid_cnt != 0) begin
            fails++;
            $display("FAIL glitch_reject: key_state=%h press_acc=%h release_acc=%h valid_cnt=%0d, expected FFFF/0000/0000/0",
                     key_state, press_acc, release_acc, valid_cnt);
        end
    endtask

    task automatic test_chord();
        clear_acc();
        pressed[1] = 1'b1;
        pressed[2] = 1'b1;
        wait_row_sample(0);
        wait_row_sample(0);
        tests++;
        if (key_state !== 16'hFFF9 || key_press !== 16'h0006 || key_valid !== 1'b1 ||
            key_code !== 4'd1 || multi_key !== 1'b0) begin
            fails++;
            $display("FAIL chord_commit: key_state=%h press=%h valid=%b code=%0d multi=%b, expected FFF9/0006/1/1/0",
                     key_state, key_press, key_valid, key_code, multi_key);
        end
        @(negedge clk);
        tests++;
        if (multi_key !== 1'b1 || key_code !== 4'd1 || key_valid !== 1'b0) begin
            fails++;
            $display("FAIL chord_multi: multi=%b code=%0d valid=%b, expected 1/1/0",
                     multi_key, key_code, key_valid);
        end
        pressed[1] = 1'b0;
        wait_row_sample(0);
        wait_row_sample(0);
        tests++;
        if (key_state !== 16'hFFFB || key_release !== 16'h0002 || multi_key !== 1'b1) begin
            fails++;
            $display("FAIL chord_release1: key_state=%h release=%h multi=%b, expected FFFB/0002/1",
                     key_state, key_release, multi_key);
        end
        @(negedge clk);
        tests++;
        if (multi_key !== 1'b0 || key_code !== 4'd1) begin
            fails++;
            $display("FAIL chord_multi_clear: multi=%b code=%0d, expected 0/1", multi_key, key_code);
        end
        pressed[2] = 1'b0;
        wait_row_sample(0);
        wait_row_sample(0);
        tests++;
        if (key_state !== 16'hFFFF || key_release !== 16'h0004 || valid_cnt != 1) begin
            fails++;
            $display("FAIL chord_release2: key_state=%h release=%h valid_cnt=%0d, expected FFFF/0004/1",
                     key_state, key_release, valid_cnt);
        end
    endtask

    task automatic test_reset_mid_debounce();
        pressed[6] = 1'b1;
        wait_row_sample(1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_debounce");
        @(negedge clk);
        rst_n = 1'b1;
        clear_acc();
        wait_row_sample(1);
        tests++;
        if (key_state !== 16'hFFFF || press_acc !== 16'h0000 || valid_cnt != 0) begin
            fails++;
            $display("FAIL post_reset_single_sample: key_state=%h press_acc=%h valid_cnt=%0d, expected FFFF/0000/0",
                     key_state, press_acc, valid_cnt);
        end
        wait_row_sample(1);
        tests++;
        if (key_state !== 16'hFFBF || key_press !== 16'h0040 || key_code !== 4'd6) begin
            fails++;
            $display("FAIL post_reset_commit: key_state=%h press=%h code=%0d, expected FFBF/0040/6",
                     key_state, key_press, key_code);
        end
        pressed[6] = 1'b0;
        wait_row_sample(1);
        wait_row_sample(1);
        tests++;
        if (key_state !== 16'hFFFF) begin
            fails++;
            $display("FAIL post_reset_release: key_state=%h expected FFFF", key_state);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        pressed = '0;
        clear_acc();
        test_reset();
        test_press();
        test_release();
        test_glitch();
        test_chord();
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_keypad_scan.md
Name: matrix_keypad_scan

Overview:
Parametrised ROWS x COLS matrix keypad scanner for the piano front-end. It drives one active-low row per scan slot and samples the active-low columns. Each key is debounced with a configurable consecutive-sample filter. Outputs are a debounced level vector, per-key press/release pulses, and an encoded key code for the note/tone logic. Everything runs on clk with a clock-enable tick; no derived clocks.

Parameters:
ROWS, 4, number of row lines driven (>=1)
COLS, 4, number of column lines sampled (>=1)
SCAN_DIV, 60000, clk cycles per row slot (>=2)
DEBOUNCE, 2, consecutive disagreeing samples needed to flip a key state (>=1; 1 = no filtering)
Derived localparams: NKEYS = ROWS*COLS; KW = clog2(NKEYS), minimum 1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
col  in  COLS  column inputs, active-low (0 = key closed on the driven row)
row  out  ROWS  row drive, one-hot active-low
key_state  out  NKEYS  debounced level; bit i = 0 means key i is pressed
key_press  out  NKEYS  1-clk pulse per key on a debounced press
key_release  out  NKEYS  1-clk pulse per key on a debounced release
key_valid  out  1  1-clk pulse when at least one new press is committed
key_code  out  KW  index of the lowest-numbered newly pressed key; held until the next key_valid
multi_key  out  1  level; 1 while two or more keys are debounced-pressed

Behaviour:
- Key index: i = r*COLS + c, where r is the row driven low and c is the column bit.
- Reset values: row = all ones except bit 0 low; slot counter = 0; scan index = 0; key_state = all ones; debounce counters = 0; key_press, key_release, key_valid, multi_key = 0; key_code = 0.
- Prescaler: cnt counts 0..SCAN_DIV-1 and wraps. tick = (cnt == SCAN_DIV-1).
- On a tick cycle, the following happen in one clk edge:
  - col is sampled for the keys of the current row r. The row has been held for the full slot, which gives settling time.
  - row advances to r+1. It wraps from ROWS-1 to 0, so the low bit rotates upward.
- Debounce, per key, is evaluated only on ticks of that key's row:
  - If sample == key_state[i], the counter clears.
  - Otherwise the counter increments.
  - When the counter would reach DEBOUNCE, key_state[i] takes the sample value and the counter clears.
  - Counter width: clog2(DEBOUNCE+1).
- Pulses are registered together with key_state, so they go high in the same cycle key_state changes and stay high exactly 1 clk.
  - key_press[i] = 1 on a 1->0 transition of key_state[i].
  - key_release[i] = 1 on a 0->1 transition of key_state[i].
- Latency: a clean press is committed on the DEBOUNCE-th row-r tick after the press, i.e. at most DEBOUNCE*ROWS*SCAN_DIV clk after the first sample.
- Encoder:
  - key_valid pulses with the committed press pulses, and key_code updates in the same cycle.
  - Simultaneous presses (possible only within one row) report the lowest index. The other keys still pulse key_press.
  - Releases never assert key_valid.
- multi_key: registered popcount(~key_state) >= 2, updated the cycle after key_state changes.
- A press shorter than DEBOUNCE row samples produces no state change and no pulses. Bouncing resets the counter on each agreeing sample.
- Asynchronous reset mid-scan or mid-debounce returns all outputs to reset values immediately. Scanning restarts at row 0.
- Ghosting: no suppression. multi_key is provided so downstream logic can ignore chords.

Decomposition:
- Package keypad_pkg: clog2 constant function; default parameter values; a row_onehot_low(r) helper.
- One sub-module, keypad_debounce_cell: a single-key counter plus state flop with press/release outputs. Instantiated NKEYS times via generate, with enable = tick & (scan index == row of key).
- Prescaler, row ring, encoder and popcount stay in the top level.

Test Plan (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2; frame = 16 clk):
- Reset and scan: after reset, row=4'b1110 and key_state=16'hFFFF. row goes 1101 at clk 4, 1011 at 8, 0111 at 12, and wraps to 1110 at 16.
- Press key 6 (model drives col[2]=0 whenever row[1]=0): on the 2nd row-1 tick, key_state[6]=0, key_press=16'h0040 for 1 clk, key_valid=1, key_code=6. multi_key stays 0.
- Glitch: key 6 closed for exactly one row-1 sample -> key_state stays 16'hFFFF; no key_press, key_release or key_valid.
- Release key 6 after commit: on the 2nd high sample, key_release=16'h0040 for 1 clk, key_state=16'hFFFF, key_valid=0. key_code stays 6.
- Chord: keys 1 and 2 pressed together -> key_press=16'h0006 in one cycle, key_code=1, multi_key=1 one clk later. Releasing key 1 -> multi_key=0.
- Reset mid-debounce: key 6 seen low once, then rst_n asserted -> outputs return to reset values at once. After release of reset, one more low sample does not commit the press.
